// File: rtl/mult_pkg.sv
// mult_pkg: shared state enumeration and default operand width for the multiplier
package mult_pkg;
    localparam int WIDTH_DEF = 32;
    typedef enum logic [1:0] {IDLE, LOAD, CALC, DONE} state_t;
endpackage

// File: rtl/mult_iter_cnt.sv
// mult_iter_cnt: saturating iteration counter with terminal flag at WIDTH-1
module mult_iter_cnt import mult_pkg::*; #(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CW    = $clog2(WIDTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] cnt,
    output logic          term
);
    always_ff @(posedge clk or posedge rst)
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en && cnt != CW'(WIDTH))
            cnt <= cnt + CW'(1);
    assign term = cnt == CW'(WIDTH - 1);
endmodule

// File: rtl/mult_ctrl.sv
// mult_ctrl: add/shift multiplier control FSM driving the product register
module mult_ctrl import mult_pkg::*; #(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CW    = $clog2(WIDTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic          lsb,
    output logic          run,
    output logic          srtctrl,
    output logic          wrctrl,
    output logic          ready,
    output logic          busy,
    output logic [CW-1:0] iter
);
    state_t state;
    logic   term;
    logic   go;
    assign go = start && (state == IDLE || state == DONE);
    always_ff @(posedge clk or posedge rst)
        if (rst)
            state <= IDLE;
        else if (abort)
            state <= IDLE;
        else
            case (state)
                IDLE:    state <= start ? LOAD : IDLE;
                LOAD:    state <= CALC;
                CALC:    state <= term ? DONE : CALC;
                DONE:    state <= start ? LOAD : DONE;
                default: state <= IDLE;
            endcase
    assign run     = state == LOAD;
    assign srtctrl = state == CALC;
    assign wrctrl  = srtctrl && lsb;
    assign ready   = state == DONE;
    assign busy    = run || srtctrl;
    // cleared on entry to LOAD so iter already reads 0 during the load cycle
    mult_iter_cnt #(.WIDTH(WIDTH), .CW(CW)) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (abort || go),
        .en   (srtctrl),
        .cnt  (iter),
        .term (term)
    );
endmodule

// File: tb/tb_mult_ctrl.sv
// tb_mult_ctrl: randomized check of mult_ctrl against a cycle and product model
module tb_mult_ctrl;
    localparam int W  = 32;
    localparam int CW = $clog2(W) + 1;
    logic clk, rst, start, abort, lsb;
    logic run, srtctrl, wrctrl, ready, busy;
    logic [CW-1:0] iter;
    logic [W-1:0] mcand, mplier;
    logic [2*W-1:0] prod;
    int total, bad;

    mult_ctrl #(.WIDTH(W), .CW(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .lsb(lsb),
        .run(run), .srtctrl(srtctrl), .wrctrl(wrctrl), .ready(ready),
        .busy(busy), .iter(iter)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // product register driven by the DUT's control outputs
    assign lsb = prod[0];
    always @(posedge clk)
        if (run)
            prod <= {{W{1'b0}}, mplier};
        else if (srtctrl)
            prod <= {{1'b0, prod[2*W-1:W]} + {1'b0, wrctrl ? mcand : {W{1'b0}}}, prod[W-1:1]};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_run"}, 64'(run), 64'(0));
        chk({tag, "_srt"}, 64'(srtctrl), 64'(0));
        chk({tag, "_wr"}, 64'(wrctrl), 64'(0));
        chk({tag, "_ready"}, 64'(ready), 64'(0));
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_iter"}, 64'(iter), 64'(0));
    endtask

    // ev: 0 plain, 1 start pulse at iter 10, 2 abort at iter 17, 3 async rst at iter 17
    task automatic mul(input logic [W-1:0] a, input logic [W-1:0] b, input int ev);
        logic e_srt, e_wr;
        int e_it;
        mcand = a;
        mplier = b;
        start = 1;
        @(posedge clk);
        @(negedge clk);
        start = 0;
        for (int k = 1; k <= W + 2; k++) begin
            e_srt = k >= 2 && k <= W + 1;
            e_wr  = e_srt && b[e_srt ? k - 2 : 0];
            e_it  = k <= 1 ? 0 : (k >= W + 2 ? W : k - 2);
            chk("run", 64'(run), 64'(k == 1));
            chk("srt", 64'(srtctrl), 64'(e_srt));
            chk("wr", 64'(wrctrl), 64'(e_wr));
            chk("ready", 64'(ready), 64'(k == W + 2));
            chk("busy", 64'(busy), 64'(k <= W + 1));
            chk("iter", 64'(iter), 64'(e_it));
            if (ev == 1)
                start = k == 12;
            if (ev == 2 && k == 19) begin
                abort = 1;
                @(negedge clk);
                abort = 0;
                chk_quiet("abort");
                repeat (3) begin
                    @(negedge clk);
                    chk("abort_ready", 64'(ready), 64'(0));
                    chk("abort_busy", 64'(busy), 64'(0));
                end
                return;
            end
            if (ev == 3 && k == 19) begin
                #2 rst = 1;
                #1 chk_quiet("rst_mid");
                @(negedge clk);
                rst = 0;
                return;
            end
            if (k == W + 2)
                chk("result", prod, 64'(a) * 64'(b));
            else
                @(negedge clk);
        end
    endtask

    task automatic idle_done(input int n);
        repeat (n) begin
            @(negedge clk);
            chk("hold_ready", 64'(ready), 64'(1));
            chk("hold_iter", 64'(iter), 64'(W));
            chk("hold_srt", 64'(srtctrl), 64'(0));
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst = 1;
        start = 0;
        abort = 0;
        mcand = 0;
        mplier = 0;
        repeat (2) @(negedge clk);
        chk_quiet("reset");
        rst = 0;
        @(negedge clk);
        chk_quiet("idle");
        mul(32'd5, 32'd3, 0);
        idle_done(2);
        mul($urandom, 32'd0, 0);
        idle_done(1);
        mul($urandom, $urandom, 1);
        idle_done(1);
        mul($urandom, $urandom, 2);
        mul($urandom, $urandom, 3);
        mul($urandom, $urandom, 0);
        mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        idle_done(1);
        for (int i = 0; i < 6; i++) begin
            mul($urandom, $urandom, 0);
            if (i[0])
                idle_done(1);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mult_ctrl.md
MULT_CTRL -- requirements
Module: mult_ctrl

Interface
REQ-001 Parameter WIDTH, default 32: operand width, which equals the number of add/shift iterations.
REQ-002 Parameter CW, default $clog2(WIDTH)+1: iteration counter width.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  request a new multiply; sampled only in IDLE and DONE.
REQ-006 abort  input  1  synchronous cancel; honoured in every state.
REQ-007 lsb  input  1  bit 0 of the product register.
REQ-008 run  output  1  load the multiplier into the product register (low half), clearing the high half.
REQ-009 srtctrl  output  1  shift the product register right by 1 this cycle.
REQ-010 wrctrl  output  1  write the ALU sum into the high half together with the shift.
REQ-011 ready  output  1  product register holds a completed result.
REQ-012 busy  output  1  multiply in progress (LOAD or CALC).
REQ-013 iter  output  CW  number of iterations completed in the current operation.

Function
REQ-014 FSM states SHALL be IDLE, LOAD, CALC and DONE, held in a registered state variable.
REQ-015 IDLE: all control outputs are 0; start=1 moves to LOAD; otherwise the FSM stays in IDLE.
REQ-016 LOAD: run=1 for exactly one cycle, iter is cleared to 0, and the FSM moves to CALC unconditionally.
REQ-017 CALC: srtctrl=1 every cycle; wrctrl=lsb (combinational from lsb); iter increments by 1 per cycle.
REQ-018 CALC SHALL last exactly WIDTH cycles; on the cycle where iter==WIDTH-1 the FSM moves to DONE and iter becomes WIDTH.
REQ-019 DONE: ready=1, srtctrl=0, wrctrl=0, run=0, and iter holds at WIDTH.
REQ-020 DONE: start=1 moves directly to LOAD (back-to-back operation) and clears ready; otherwise the FSM stays in DONE.
REQ-021 busy SHALL be 1 exactly in LOAD and CALC.
REQ-022 run, srtctrl, wrctrl and ready SHALL be decoded from the state register only, except wrctrl, which also depends on lsb.
REQ-023 run and srtctrl SHALL never be 1 in the same cycle.
REQ-024 wrctrl SHALL be 0 whenever srtctrl is 0.
REQ-025 Latency: start sampled at edge N gives run in cycle N+1, srtctrl in cycles N+2..N+WIDTH+1, and ready from cycle N+WIDTH+2.
REQ-026 start in LOAD or CALC SHALL be ignored and not queued.
REQ-027 abort=1 in any state SHALL move the FSM to IDLE on the next edge and clear iter; abort has priority over start.
REQ-028 An aborted operation SHALL never assert ready.
REQ-029 iter SHALL not wrap; it saturates at WIDTH.

Reset
REQ-030 rst=1 SHALL force IDLE and iter=0 immediately, independent of clk.
REQ-031 While rst=1, run, srtctrl, wrctrl, ready and busy SHALL all be 0.
REQ-032 Reset in the middle of CALC SHALL discard the operation, leaving no pending state.
REQ-033 After rst is released, the first start SHALL follow the REQ-025 timing exactly.

Structure
REQ-034 The shared package mult_pkg SHALL hold the state enumeration (IDLE, LOAD, CALC, DONE) and the default WIDTH constant; the product register uses the same WIDTH constant.
REQ-035 The iteration counter SHALL be one sub-module, mult_iter_cnt, with clear, enable, a saturating count and a terminal flag (count==WIDTH-1); the FSM stays in mult_ctrl.

Verification
REQ-036 Multiply 5 by 3, with lsb driven from a product-register model: run in cycle 1, 32 srtctrl cycles, wrctrl=1 in iterations 0 and 1 only, ready in cycle 34, model result 15.
REQ-037 Multiplier 0: wrctrl stays 0 for all 32 CALC cycles, ready is asserted, and the result is 0.
REQ-038 start pulsed in CALC at iter=10: no effect, and ready arrives at the normal cycle.
REQ-039 abort at iter=17: the FSM is in IDLE next cycle, iter=0, busy=0, and ready is never asserted.
REQ-040 rst asserted asynchronously mid-CALC: all outputs are 0 before the next clock edge; a fresh start then completes in 34 cycles.
REQ-041 start held in DONE (0xFFFFFFFF by 0xFFFFFFFF): LOAD follows immediately, ready drops, the second result is 0xFFFFFFFE00000001, and there are no idle cycles between operations.
